// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory freeze,
// taken-branch flushes, saturating perf counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_IDrs1,
   input  logic [4:0]       IF_IDrs2,
   input  logic             IF_IDuseRs1,
   input  logic             IF_IDuseRs2,
   input  logic [4:0]       ID_EXrd,
   input  logic             ID_EXmemRead,
   input  logic             EXbranchTaken,
   input  logic             EX_MEMmemReq,
   input  logic             dmemReady,
   output logic             PCWrite,
   output logic             IF_IDWrite,
   output logic             ID_EXbubble,
   output logic             IF_IDflush,
   output logic             ID_EXflush,
   output logic             pipeFreeze,
   output logic             memErr,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StRedirect = 2'd1,
      StWait     = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

   state_e           state_q, state_d;
   logic             pend_redirect_q, pend_redirect_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use, mem_wait;
   logic freeze_cyc, decide_en;
   logic pc_write, if_id_write, bubble, if_flush, ex_flush;

   assign load_use = ID_EXmemRead && (ID_EXrd != 5'd0) &&
                     ((IF_IDuseRs1 && (IF_IDrs1 == ID_EXrd)) ||
                      (IF_IDuseRs2 && (IF_IDrs2 == ID_EXrd)));
   assign mem_wait = EX_MEMmemReq && !dmemReady;

   always_comb begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      bubble          = 1'b0;
      if_flush        = 1'b0;
      ex_flush        = 1'b0;
      freeze_cyc      = 1'b0;
      decide_en       = 1'b0;
      state_d         = state_q;
      pend_redirect_d = pend_redirect_q;
      wait_cnt_d      = wait_cnt_q;
      mem_err_d       = mem_err_q;
      stall_cnt_d     = stall_cnt_q;
      flush_cnt_d     = flush_cnt_q;

      case (state_q)
         StRun, StRedirect: begin
            if (mem_wait) begin
               freeze_cyc = 1'b1;
               wait_cnt_d = CntOne;
               state_d    = StWait;
               // The stale fetch behind the redirect is still owed a flush after the freeze.
               if (state_q == StRedirect) pend_redirect_d = 1'b1;
            end else begin
               if (state_q == StRedirect) if_flush = 1'b1;
               decide_en = 1'b1;
            end
         end
         StWait: begin
            if (!dmemReady) begin
               freeze_cyc = 1'b1;
               wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntOne;
            end else begin
               if (pend_redirect_q) if_flush = 1'b1;
               pend_redirect_d = 1'b0;
               decide_en       = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      if (freeze_cyc) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if (wait_cnt_d >= TimeoutVal) mem_err_d = 1'b1;
      end else if (decide_en) begin
         state_d = StRun;
         if (EXbranchTaken) begin
            if_flush = 1'b1;
            ex_flush = 1'b1;
            state_d  = StRedirect;
            if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CntOne;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
         end
      end

      if ((freeze_cyc || bubble) && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CntOne;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StRun;
         pend_redirect_q <= 1'b0;
         wait_cnt_q      <= '0;
         mem_err_q       <= 1'b0;
         stall_cnt_q     <= '0;
         flush_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         pend_redirect_q <= pend_redirect_d;
         wait_cnt_q      <= wait_cnt_d;
         mem_err_q       <= mem_err_d;
         stall_cnt_q     <= stall_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
      end
   end

   // Every control output is forced low while reset is held.
   assign PCWrite     = rst_n && pc_write;
   assign IF_IDWrite  = rst_n && if_id_write;
   assign ID_EXbubble = rst_n && bubble;
   assign IF_IDflush  = rst_n && if_flush;
   assign ID_EXflush  = rst_n && ex_flush;
   assign pipeFreeze  = rst_n && freeze_cyc;
   assign memErr      = mem_err_q;
   assign stallCycles = stall_cnt_q;
   assign flushCount  = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline, working alongside the forwarding logic. It detects load-use hazards the forwarding paths cannot cover, freezes the whole pipeline while data memory is not ready, and flushes wrong-path instructions after a taken branch resolved in EX. Because instruction memory is synchronous, a redirect discards one extra stale fetch. The block also keeps saturating stall and flush counters and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of performance counters
- TIMEOUT, 255, consecutive WAIT cycles after which memErr sets (1..2^CNT_W-1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- IF_IDrs1, IF_IDrs2  in  5  source registers of instruction in ID
- IF_IDuseRs1, IF_IDuseRs2  in  1  ID instruction actually reads rs1/rs2
- ID_EXrd  in  5  destination of instruction in EX
- ID_EXmemRead  in  1  instruction in EX is a load
- EXbranchTaken  in  1  taken branch/jump resolved in EX this cycle
- EX_MEMmemReq  in  1  instruction in MEM accesses data memory
- dmemReady  in  1  data memory completes access this cycle
- PCWrite  out  1  PC may update
- IF_IDWrite  out  1  IF/ID register may load
- ID_EXbubble  out  1  load NOP into ID/EX
- IF_IDflush  out  1  clear IF/ID to NOP
- ID_EXflush  out  1  clear ID/EX to NOP
- pipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB (no writeback)
- memErr  out  1  sticky data-memory timeout
- stallCycles  out  CNT_W  saturating count of stall/freeze cycles
- flushCount  out  CNT_W  saturating count of taken redirects

## Operation
- LU = ID_EXmemRead & (ID_EXrd!=0) & ((IF_IDuseRs1 & IF_IDrs1==ID_EXrd) | (IF_IDuseRs2 & IF_IDrs2==ID_EXrd)).
- MW = EX_MEMmemReq & ~dmemReady.
- Default outputs: PCWrite=1, IF_IDWrite=1, all others 0.
- State RUN, priority MW > EXbranchTaken > LU:
  - MW: PCWrite=0, IF_IDWrite=0, pipeFreeze=1; waitCnt<=1; next WAIT.
  - Branch: IF_IDflush=1, ID_EXflush=1, PCWrite=1 (loads target); flushCount++; next REDIRECT.
  - LU: PCWrite=0, IF_IDWrite=0, ID_EXbubble=1; stallCycles++; stay RUN.
- State REDIRECT: IF_IDflush=1 to discard the stale fetch. Branch/LU are evaluated as in RUN.
  - MW: freeze as in RUN, IF_IDflush=0, set pendRedirect; next WAIT.
  - Otherwise: next RUN, or REDIRECT again if EXbranchTaken.
- State WAIT:
  - dmemReady=0: freeze outputs as in RUN-MW; stallCycles++; waitCnt++ (saturating). When waitCnt reaches TIMEOUT with dmemReady still 0, memErr<=1. memErr clears only on reset. Stay in WAIT.
  - dmemReady=1: freeze released this cycle. Apply RUN decisions with MW=0. If pendRedirect, additionally IF_IDflush=1 and clear pendRedirect. Next RUN, or REDIRECT if branch.
- Counters saturate at all-ones. stallCycles increments once per stalled or frozen cycle, never twice.
- State encoding is free; unused encodings recover to RUN.

## Timing
- Control outputs are combinational from the current state and inputs, valid in the same cycle. State, counters, memErr, pendRedirect and waitCnt update on the rising edge of clk.
- Reset (rst_n=0, asynchronous):
  - State=RUN; counters, waitCnt, memErr and pendRedirect cleared.
  - While in reset: PCWrite=0, IF_IDWrite=0, bubble/flush/freeze outputs=0.
  - Reset asserted during WAIT or REDIRECT abandons the state; no pending flush survives.
- Load-use costs exactly 1 bubble cycle. A redirect costs 2 flushed fetch slots.
- MW and a branch in the same cycle: freeze wins. The branch stays in EX and is taken on the release cycle.
- Branch and LU in the same cycle: flush wins; no bubble, no stall count.

## Test plan
- Load-use:
  - Stimulus: ID_EXmemRead=1, ID_EXrd=5, IF_IDrs1=5, useRs1=1.
  - Required: 1 cycle with PCWrite=0, IF_IDWrite=0, ID_EXbubble=1; stallCycles 0->1.
  - Same stimulus with rd=0 or useRs1=0: no stall.
- Taken branch:
  - Stimulus: EXbranchTaken=1 in RUN.
  - Required: cycle N has IF_IDflush=1 and ID_EXflush=1; cycle N+1 has IF_IDflush=1 only; flushCount=1; back to RUN at N+2.
- Memory wait:
  - Stimulus: MW held 3 cycles, then dmemReady=1.
  - Required: pipeFreeze=1 for 3 cycles, 0 on the ready cycle; stallCycles=3; memErr=0.
- Redirect then memory wait:
  - Stimulus: MW raised in the REDIRECT cycle, ready after 2 cycles.
  - Required: IF_IDflush=1 on the release cycle; pendRedirect cleared afterwards.
- Timeout:
  - Stimulus: TIMEOUT=4, dmemReady held 0 for 6 cycles.
  - Required: memErr=1 after the 4th WAIT cycle; stays 1 after ready returns until rst_n pulses low.
- Saturation and reset:
  - Stimulus: CNT_W=4; 20 stall cycles, then rst_n low mid-WAIT.
  - Required: stallCycles holds at 15; after reset all counters=0, state=RUN, outputs at their reset values immediately.
